// File: rtl/move_link_tx.sv
// Serial transmitter for a 3-bit paddle move code: start, d0..d2, odd parity, ID, stop.
// Frames go out on a move change, on the first enabled cycle after reset, and as a keepalive.
module move_link_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int KEEPALIVE    = 555556,
  parameter bit PLAYER_ID    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] move_in,
  input  logic       enable,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] sent_move
);

  // state     | meaning
  // S_IDLE    | line high, trigger evaluated every cycle
  // S_START   | start bit (0)
  // S_DATA    | d0..d2, bit_cnt selects the bit
  // S_PARITY  | odd parity over d0..d2
  // S_ID      | PLAYER_ID
  // S_STOP    | stop bit (1), frame_done pulses on exit

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int KA_W   = (KEEPALIVE > 1) ? $clog2(KEEPALIVE) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [KA_W-1:0]   KA_MAX    = KA_W'(KEEPALIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_ID, S_STOP
  } state_t;

  state_t            state, state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [1:0]        bit_cnt, bit_cnt_d;
  logic [2:0]        data;
  logic              first;
  logic [KA_W-1:0]   ka_cnt;
  logic              bit_done, trigger, start_frame, tx_d;

  assign bit_done    = (baud_cnt == BAUD_LAST);
  assign trigger     = enable && (first || (move_in != sent_move) || (ka_cnt >= KA_MAX));
  assign start_frame = (state == S_IDLE) && trigger;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    case (state)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (trigger) state_d = S_START;
      end
      S_START:  if (bit_done) state_d = S_DATA;
      S_DATA: begin
        if (bit_done) begin
          if (bit_cnt == 2'd2) begin
            state_d   = S_PARITY;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + 2'd1;
          end
        end
      end
      S_PARITY: if (bit_done) state_d = S_ID;
      S_ID:     if (bit_done) state_d = S_STOP;
      S_STOP:   if (bit_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Line value is derived from the next state so tx can be a plain register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data[bit_cnt_d];
      S_PARITY: tx_d = ~(^data);
      S_ID:     tx_d = PLAYER_ID;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      data       <= '0;
      sent_move  <= '0;
      first      <= 1'b1;
      ka_cnt     <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      baud_cnt   <= ((state == S_IDLE) || bit_done) ? '0 : baud_cnt + BAUD_W'(1);
      bit_cnt    <= bit_cnt_d;
      tx         <= tx_d;
      busy       <= (state_d != S_IDLE);
      frame_done <= (state == S_STOP) && bit_done;
      if (start_frame) begin
        data      <= move_in;
        sent_move <= move_in;
        first     <= 1'b0;
        ka_cnt    <= '0;
      end else if (ka_cnt < KA_MAX) begin
        ka_cnt <= ka_cnt + KA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_move_link_tx.sv
// Randomized scoreboard bench for move_link_tx: a rule-level model predicts frame start
// edges and contents, a line monitor decodes tx and compares against the queue.
module tb_move_link_tx;
  localparam int C   = 4;
  localparam int K   = 100;
  localparam bit PID = 1'b1;
  localparam int FL  = 7 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] move_in = 3'd0;
  logic       enable = 1'b0;
  logic       tx, busy, frame_done;
  logic [2:0] sent_move;

  move_link_tx #(.CLKS_PER_BIT(C), .KEEPALIVE(K), .PLAYER_ID(PID)) dut (
    .clk(clk), .rst_n(rst_n), .move_in(move_in), .enable(enable),
    .tx(tx), .busy(busy), .frame_done(frame_done), .sent_move(sent_move)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         start;
    logic [2:0] move;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rst_seen = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Model: a frame may start once the previous one has fully ended (plus one edge),
  // when enabled and either first, changed, or K edges have passed since the last start/reset.
  bit         m_first = 1'b1;
  logic [2:0] m_sent = 3'd0;
  int         m_mark = 0;
  int         m_free = 0;

  always @(posedge clk) begin
    cyc++;
    rst_seen = !rst_n;
    if (!rst_n) begin
      m_first = 1'b1;
      m_sent  = 3'd0;
      m_mark  = cyc;
      m_free  = cyc + 1;
    end else if (cyc >= m_free && enable &&
                 (m_first || move_in != m_sent || (cyc - m_mark) >= K)) begin
      q.push_back('{start: cyc, move: move_in});
      m_first = 1'b0;
      m_sent  = move_in;
      m_mark  = cyc;
      m_free  = cyc + FL + 1;
    end
  end

  function automatic logic [6:0] frame_bits(input logic [2:0] m);
    int ones = m[0] + m[1] + m[2];
    logic par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, PID, par, m[2], m[1], m[0], 1'b0};
  endfunction

  bit         collecting = 1'b0;
  bit         spurious = 1'b0;
  int         n = 0;
  logic       samp [FL];
  exp_t       cur;

  always @(negedge clk) begin
    if (rst_seen) begin
      collecting = 1'b0;
      chk(tx === 1'b1 && busy === 1'b0 && frame_done === 1'b0, "reset_outputs",
          {tx, busy, frame_done}, 3'b100);
    end else if (!collecting) begin
      chk(frame_done === 1'b0, "stray_frame_done", frame_done, 0);
      if (tx === 1'b0) begin
        chk(q.size() != 0, "frame_expected", cyc, -1);
        spurious = (q.size() == 0);
        if (!spurious) begin
          cur = q.pop_front();
          chk(cyc == cur.start, "start_edge", cyc, cur.start);
          chk(sent_move === cur.move, "sent_move", sent_move, cur.move);
        end
        chk(busy === 1'b1, "busy_at_start", busy, 1);
        collecting = 1'b1;
        samp[0] = tx;
        n = 1;
      end
    end else if (n < FL) begin
      samp[n] = tx;
      n++;
    end else begin
      logic [6:0] got;
      bit uniform = 1'b1;
      for (int b = 0; b < 7; b++) begin
        got[b] = samp[b*C];
        for (int k = 1; k < C; k++)
          if (samp[b*C+k] !== samp[b*C]) uniform = 1'b0;
      end
      if (!spurious) begin
        chk(uniform && got == frame_bits(cur.move), "frame_bits", got, frame_bits(cur.move));
        chk(frame_done === 1'b1 && busy === 1'b0 && tx === 1'b1, "frame_end",
            {frame_done, busy, tx}, 3'b101);
      end
      collecting = 1'b0;
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy) begin
        got = 1'b1;
        break;
      end
      cycles(1);
    end
    chk(got, "wait_busy", got, 1);
  endtask

  initial begin
    cycles(3);
    chk(tx === 1'b1 && busy === 1'b0 && frame_done === 1'b0 && sent_move === 3'd0,
        "reset_state", {tx, busy, frame_done, sent_move}, 6'b100000);

    rst_n = 1'b1; enable = 1'b1; move_in = 3'd4;
    cycles(40);
    move_in = 3'd7;
    cycles(250);

    move_in = 3'd4;
    wait_busy();
    cycles(5);
    move_in = 3'd3;
    cycles(60);

    move_in = 3'd4;
    wait_busy();
    cycles(3);
    move_in = 3'd2;
    cycles(4);
    move_in = 3'd4;
    cycles(150);

    enable = 1'b0;
    cycles(300);
    enable = 1'b1;
    cycles(40);

    move_in = 3'd5;
    wait_busy();
    cycles(3 * C);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(40);

    for (int it = 0; it < 150; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 45)      move_in = 3'($urandom_range(0, 7));
      else if (r < 57) enable = ($urandom_range(0, 3) != 0);
      else if (r < 60) begin
        rst_n = 1'b0;
        cycles($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      cycles($urandom_range(1, 40));
    end

    enable = 1'b0;
    begin
      bit drained = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if (q.size() == 0 && !collecting) begin
          drained = 1'b1;
          break;
        end
        cycles(1);
      end
      chk(drained, "drain", q.size(), 0);
    end
    cycles(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
